// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fwd_pkg
// Description : Shared types and widths for the execute-stage bypass network.
// Revision    : 1.0 - initial release
// ============================================================================
package fwd_pkg;

   localparam int XLEN       = 64;
   localparam int REG_AW     = 5;
   localparam int FWD_WAIT_W = 8;

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      HELD  = 1'b1
   } fwd_slot_state_e;

   typedef struct packed {
      logic              en;
      logic [REG_AW-1:0] rd;
      logic              ok;
      logic [XLEN-1:0]   data;
   } fwd_stage_t;

endpackage
`default_nettype wire

// File: rtl/fwd_bypass_net_if.sv
`default_nettype none
// ============================================================================
// Module      : fwd_bypass_net_if
// Description : ID/EXE operand, forwarding-stage and operand-result bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface fwd_bypass_net_if #(
   parameter int NUM_SRC = 2,
   parameter int NUM_FWD = 2,
   parameter int XLEN    = fwd_pkg::XLEN,
   parameter int REG_AW  = fwd_pkg::REG_AW
);
   logic                                 exe_ready;
   logic                                 exe_flush;
   logic [NUM_SRC-1:0]                   src_en;
   logic [NUM_SRC-1:0][REG_AW-1:0]       src_idx;
   logic [NUM_SRC-1:0][XLEN-1:0]         src_rf;
   logic [NUM_FWD-1:0]                   fwd_en;
   logic [NUM_FWD-1:0][REG_AW-1:0]       fwd_rd;
   logic [NUM_FWD-1:0]                   fwd_ok;
   logic [NUM_FWD-1:0][XLEN-1:0]         fwd_data;
   logic [NUM_SRC-1:0][XLEN-1:0]         opnd_data;
   logic [NUM_SRC-1:0]                   src_ready;
   logic                                 opnd_valid;
   logic [fwd_pkg::FWD_WAIT_W-1:0]       wait_cnt;

   modport master (
      output exe_ready, exe_flush, src_en, src_idx, src_rf,
             fwd_en, fwd_rd, fwd_ok, fwd_data,
      input  opnd_data, src_ready, opnd_valid, wait_cnt
   );

   modport slave (
      input  exe_ready, exe_flush, src_en, src_idx, src_rf,
             fwd_en, fwd_rd, fwd_ok, fwd_data,
      output opnd_data, src_ready, opnd_valid, wait_cnt
   );
endinterface
`default_nettype wire

// File: rtl/fwd_operand_slot.sv
`default_nettype none
// ============================================================================
// Module      : fwd_operand_slot
// Description : One source operand: youngest-match bypass mux plus hold slot.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_operand_slot
   import fwd_pkg::*;
#(
   parameter int NUM_FWD = 2
) (
   input  wire logic                     clk,
   input  wire logic                     rst,
   input  wire logic                     i_exe_ready,
   input  wire logic                     i_exe_flush,
   input  wire logic                     i_src_en,
   input  wire logic [REG_AW-1:0]        i_src_idx,
   input  wire logic [XLEN-1:0]          i_src_rf,
   input  wire fwd_stage_t [NUM_FWD-1:0] i_stages,
   output logic [XLEN-1:0]               o_opnd_data,
   output logic                          o_src_ready
);

   fwd_slot_state_e r_state;
   fwd_slot_state_e w_state_nxt;
   logic [XLEN-1:0] r_hold;
   logic            w_lookup;
   logic            w_hit;
   logic            w_hit_ok;
   logic [XLEN-1:0] w_hit_data;
   logic            w_resolved;
   logic [XLEN-1:0] w_live;
   logic            w_clear;
   logic            w_capture;

   assign w_lookup = i_src_en && (i_src_idx != '0);
   assign w_clear  = rst | i_exe_ready | i_exe_flush;

   // Scan oldest to youngest so the youngest matching stage overwrites the rest.
   always_comb begin
      w_hit      = 1'b0;
      w_hit_ok   = 1'b0;
      w_hit_data = '0;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         if (w_lookup && i_stages[k].en && (i_stages[k].rd == i_src_idx)) begin
            w_hit      = 1'b1;
            w_hit_ok   = i_stages[k].ok;
            w_hit_data = i_stages[k].data;
         end
      end
   end

   assign w_resolved = !w_hit || w_hit_ok;
   assign w_live     = w_hit ? w_hit_data : i_src_rf;

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      case (r_state)
         EMPTY: begin
            if (!w_clear && w_resolved) begin
               w_state_nxt = HELD;
               w_capture   = 1'b1;
            end
         end
         HELD: begin
            if (w_clear) begin
               w_state_nxt = EMPTY;
            end
         end
         default: w_state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= EMPTY;
         r_hold  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_capture) begin
            r_hold <= w_live;
         end
      end
   end

   assign o_src_ready = (r_state == HELD) || w_resolved;
   assign o_opnd_data = (r_state == HELD) ? r_hold : w_live;

endmodule
`default_nettype wire

// File: rtl/fwd_bypass_net.sv
`default_nettype none
// ============================================================================
// Module      : fwd_bypass_net
// Description : Execute-stage operand bypass network with stall hold and wait counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_bypass_net #(
   parameter int NUM_SRC = 2,
   parameter int NUM_FWD = 2,
   parameter int XLEN    = fwd_pkg::XLEN,
   parameter int REG_AW  = fwd_pkg::REG_AW
) (
   input  wire logic        clk,
   input  wire logic        rst,
   fwd_bypass_net_if.slave  bus
);
   import fwd_pkg::*;

   fwd_stage_t [NUM_FWD-1:0]        w_stages;
   logic [NUM_SRC-1:0][XLEN-1:0]    w_opnd_data;
   logic [NUM_SRC-1:0]              w_src_ready;
   logic                            w_opnd_valid;
   logic [FWD_WAIT_W-1:0]           r_wait_cnt;

   always_comb begin
      w_stages = '0;
      for (int k = 0; k < NUM_FWD; k++) begin
         w_stages[k].en   = bus.fwd_en[k];
         w_stages[k].rd   = bus.fwd_rd[k][REG_AW-1:0];
         w_stages[k].ok   = bus.fwd_ok[k];
         w_stages[k].data = bus.fwd_data[k][XLEN-1:0];
      end
   end

   generate
      for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
         fwd_operand_slot #(
            .NUM_FWD (NUM_FWD)
         ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .i_exe_ready (bus.exe_ready),
            .i_exe_flush (bus.exe_flush),
            .i_src_en    (bus.src_en[i]),
            .i_src_idx   (bus.src_idx[i]),
            .i_src_rf    (bus.src_rf[i]),
            .i_stages    (w_stages),
            .o_opnd_data (w_opnd_data[i]),
            .o_src_ready (w_src_ready[i])
         );
      end
   endgenerate

   assign w_opnd_valid = &w_src_ready;

   always_ff @(posedge clk) begin
      if (rst || bus.exe_ready || bus.exe_flush) begin
         r_wait_cnt <= '0;
      end else if (!w_opnd_valid && (r_wait_cnt != {FWD_WAIT_W{1'b1}})) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   assign bus.opnd_data  = w_opnd_data;
   assign bus.src_ready  = w_src_ready;
   assign bus.opnd_valid = w_opnd_valid;
   assign bus.wait_cnt   = r_wait_cnt;

endmodule
`default_nettype wire
